// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, default widths
// and the layout of one buffered command entry.
package alu_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_OPW   = 3;
  localparam int DEF_DEPTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b111;

  // A command entry is packed MSB-first as {op, use_acc, a, b}.
  function automatic int entry_w(input int width, input int opw);
    return opw + 1 + 2 * width;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally.
module alu_cmd_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Pointer and occupancy control; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU interface: buffers commands, issues one per cycle
// to an external combinational ALU and registers the result into a response
// port and a chaining accumulator.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OPW-1:0]           cmd_op,
  input  logic                     cmd_use_acc,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  output logic [OPW-1:0]           alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic [WIDTH-1:0]         acc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int EW = entry_w(WIDTH, OPW);

  logic [EW-1:0]    head_p0;
  logic [OPW-1:0]   head_op;
  logic             head_use_acc;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             full;
  logic             empty;
  logic             issue;

  assign {head_op, head_use_acc, head_a, head_b} = head_p0;

  // Acceptance depends on full alone; a pop in the same cycle never frees a slot early.
  assign cmd_ready = !full;
  assign issue     = !empty && (!rsp_valid || rsp_ready);

  alu_cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && !full),
    .wdata ({cmd_op, cmd_use_acc, cmd_a, cmd_b}),
    .pop   (issue),
    .rdata (head_p0),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Operand mux: drive the head command to the ALU when issuing, else park it on NOP.
  always_comb begin
    alu_op = OPW'(OP_NOP);
    alu_a  = '0;
    alu_b  = '0;
    if (issue) begin
      alu_op = head_op;
      alu_a  = head_use_acc ? acc : head_a;
      alu_b  = head_b;
    end
  end

  // ---- p0 -> p1: capture ALU result into response register and accumulator ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      acc        <= '0;
    end else if (issue) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      acc        <= alu_result;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
